// File: rtl/eff_addr_seq.sv
// Effective-address sequencer for the 6502 core: zero-page, absolute, indexed
// and pointer-indirect modes, with 6502-accurate page-cross and store fix-up timing.
module eff_addr_seq #(
  parameter int unsigned DATA_W      = 8,
  parameter bit          JMP_IND_BUG = 1'b1,
  parameter bit          STORE_FIX   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic                  is_write,
  input  logic [DATA_W-1:0]     op_lo,
  input  logic [DATA_W-1:0]     op_hi,
  input  logic [DATA_W-1:0]     index,
  output logic                  mem_rd,
  output logic [2*DATA_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [2*DATA_W-1:0]   ea,
  output logic                  ea_valid,
  output logic                  page_cross,
  output logic                  busy
);

  localparam int unsigned ADDR_W = 2 * DATA_W;

  localparam logic [2:0] M_ZP   = 3'd0;
  localparam logic [2:0] M_ZPI  = 3'd1;
  localparam logic [2:0] M_ABSI = 3'd3;
  localparam logic [2:0] M_INDX = 3'd4;
  localparam logic [2:0] M_INDY = 3'd5;
  localparam logic [2:0] M_IND  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_RD_HI  = 3'd2,
    S_CAP_HI = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   op_lo_q, op_lo_d;
  logic [DATA_W-1:0]   op_hi_q, op_hi_d;
  logic [DATA_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   pend_ea_q, pend_ea_d;
  logic                pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                pc_q, pc_d;
  logic                ea_valid_q, ea_valid_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;

  logic [ADDR_W:0]     idle_add_c;
  logic [ADDR_W:0]     cap_add_c;

  // Indexed add: {low-byte carry, base + zero-extended index mod 2^ADDR_W}
  function automatic logic [ADDR_W:0] idx_add(input logic [ADDR_W-1:0] base,
                                              input logic [DATA_W-1:0] idx);
    logic [DATA_W:0]   lo_sum;
    logic [ADDR_W-1:0] sum;
    lo_sum = {1'b0, base[DATA_W-1:0]} + {1'b0, idx};
    sum    = base + {{DATA_W{1'b0}}, idx};
    return {lo_sum[DATA_W], sum};
  endfunction

  // Address of the pointer's low byte
  function automatic logic [ADDR_W-1:0] ptr_lo(input logic [2:0] m,
                                              input logic [DATA_W-1:0] lo,
                                              input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W-1:0] idx);
    case (m)
      M_INDX:  return {{DATA_W{1'b0}}, DATA_W'(lo + idx)};
      M_INDY:  return {{DATA_W{1'b0}}, lo};
      default: return {hi, lo};
    endcase
  endfunction

  // Address of the pointer's high byte; zero-page pointers wrap within page 0
  function automatic logic [ADDR_W-1:0] ptr_hi(input logic [2:0] m,
                                              input logic [DATA_W-1:0] lo,
                                              input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W-1:0] idx);
    logic [ADDR_W-1:0] p;
    p = ptr_lo(m, lo, hi, idx);
    if (m == M_IND) begin
      if (JMP_IND_BUG) return {hi, DATA_W'(lo + DATA_W'(1))};
      else             return p + ADDR_W'(1);
    end
    return {{DATA_W{1'b0}}, DATA_W'(p[DATA_W-1:0] + DATA_W'(1))};
  endfunction

  assign idle_add_c = idx_add({op_hi, op_lo}, index);
  assign cap_add_c  = idx_add({mem_rdata, lo_q}, idx_q);

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      wr_q       <= 1'b0;
      op_lo_q    <= '0;
      op_hi_q    <= '0;
      idx_q      <= '0;
      lo_q       <= '0;
      pend_ea_q  <= '0;
      pend_pc_q  <= 1'b0;
      ea_q       <= '0;
      pc_q       <= 1'b0;
      ea_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_q       <= wr_d;
      op_lo_q    <= op_lo_d;
      op_hi_q    <= op_hi_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      pend_ea_q  <= pend_ea_d;
      pend_pc_q  <= pend_pc_d;
      ea_q       <= ea_d;
      pc_q       <= pc_d;
      ea_valid_q <= ea_valid_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs reflect the state being entered
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_d       = wr_q;
    op_lo_d    = op_lo_q;
    op_hi_d    = op_hi_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    pend_ea_d  = pend_ea_q;
    pend_pc_d  = pend_pc_q;
    ea_d       = ea_q;
    pc_d       = pc_q;
    ea_valid_d = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          wr_d    = is_write;
          op_lo_d = op_lo;
          op_hi_d = op_hi;
          idx_d   = index;
          case (mode)
            M_ZP: begin
              ea_d = {{DATA_W{1'b0}}, op_lo};
              pc_d = 1'b0;
              state_d = S_DONE;
            end
            M_ZPI: begin
              ea_d = {{DATA_W{1'b0}}, DATA_W'(op_lo + index)};
              pc_d = 1'b0;
              state_d = S_DONE;
            end
            M_ABSI: begin
              if (idle_add_c[ADDR_W] || (is_write && STORE_FIX)) begin
                pend_ea_d = idle_add_c[ADDR_W-1:0];
                pend_pc_d = idle_add_c[ADDR_W];
                state_d   = S_FIX;
              end else begin
                ea_d    = idle_add_c[ADDR_W-1:0];
                pc_d    = idle_add_c[ADDR_W];
                state_d = S_DONE;
              end
            end
            M_INDX, M_INDY, M_IND: begin
              mem_rd_d   = 1'b1;
              mem_addr_d = ptr_lo(mode, op_lo, op_hi, index);
              state_d    = S_RD_LO;
            end
            default: begin
              ea_d = {op_hi, op_lo};
              pc_d = 1'b0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RD_LO: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = ptr_hi(mode_q, op_lo_q, op_hi_q, idx_q);
        state_d    = S_RD_HI;
      end
      S_RD_HI: begin
        lo_d    = mem_rdata;
        state_d = S_CAP_HI;
      end
      S_CAP_HI: begin
        if (mode_q == M_INDY) begin
          if (cap_add_c[ADDR_W] || (wr_q && STORE_FIX)) begin
            pend_ea_d = cap_add_c[ADDR_W-1:0];
            pend_pc_d = cap_add_c[ADDR_W];
            state_d   = S_FIX;
          end else begin
            ea_d    = cap_add_c[ADDR_W-1:0];
            pc_d    = cap_add_c[ADDR_W];
            state_d = S_DONE;
          end
        end else begin
          ea_d    = {mem_rdata, lo_q};
          pc_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_FIX: begin
        ea_d    = pend_ea_q;
        pc_d    = pend_pc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) ea_valid_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign ea         = ea_q;
  assign ea_valid   = ea_valid_q;
  assign page_cross = pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_eff_addr_seq.sv
// Directed bench for eff_addr_seq: two instances share stimulus, one with the
// JMP-indirect wrap quirk and store fix-up enabled, one with both disabled.
module tb_eff_addr_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mode;
  logic        is_write;
  logic [7:0]  op_lo, op_hi, index;

  logic        mem_rd_w   [2];
  logic [15:0] mem_addr_w [2];
  logic [7:0]  rdata_w    [2];
  logic [15:0] ea_w       [2];
  logic        ea_valid_w [2];
  logic        pc_w       [2];
  logic        busy_w     [2];

  logic [7:0]  mem [65536];

  int checks = 0;
  int errors = 0;

  // Results of the most recent transaction, per instance
  int          lat    [2];
  int          nvalid [2];
  int          nrd    [2];
  logic [15:0] ea_r   [2];
  logic        pc_r   [2];
  logic [15:0] rd_a   [2][4];

  eff_addr_seq #(.DATA_W(8), .JMP_IND_BUG(1'b1), .STORE_FIX(1'b1)) u0 (
    .Clk(clk), .Reset_n(rst_n), .start(start), .mode(mode), .is_write(is_write),
    .op_lo(op_lo), .op_hi(op_hi), .index(index),
    .mem_rd(mem_rd_w[0]), .mem_addr(mem_addr_w[0]), .mem_rdata(rdata_w[0]),
    .ea(ea_w[0]), .ea_valid(ea_valid_w[0]), .page_cross(pc_w[0]), .busy(busy_w[0])
  );

  eff_addr_seq #(.DATA_W(8), .JMP_IND_BUG(1'b0), .STORE_FIX(1'b0)) u1 (
    .Clk(clk), .Reset_n(rst_n), .start(start), .mode(mode), .is_write(is_write),
    .op_lo(op_lo), .op_hi(op_hi), .index(index),
    .mem_rd(mem_rd_w[1]), .mem_addr(mem_addr_w[1]), .mem_rdata(rdata_w[1]),
    .ea(ea_w[1]), .ea_valid(ea_valid_w[1]), .page_cross(pc_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data is returned the cycle after the read strobe
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      rdata_w[d] <= mem_rd_w[d] ? mem[mem_addr_w[d]] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; start stays high for 'hold' further cycles with altered operands
  task automatic run(input logic [2:0] m, input logic w, input logic [7:0] lo,
                     input logic [7:0] hi, input logic [7:0] idx, input int hold);
    for (int d = 0; d < 2; d++) begin
      lat[d] = -1; nvalid[d] = 0; nrd[d] = 0; ea_r[d] = 16'hxxxx; pc_r[d] = 1'bx;
    end
    start = 1'b1; mode = m; is_write = w; op_lo = lo; op_hi = hi; index = idx;
    tick();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if (mem_rd_w[d] && nrd[d] < 4) begin
          rd_a[d][nrd[d]] = mem_addr_w[d];
          nrd[d]++;
        end
        if (ea_valid_w[d]) begin
          nvalid[d]++;
          lat[d]  = cyc;
          ea_r[d] = ea_w[d];
          pc_r[d] = pc_w[d];
        end
      end
      if (cyc <= hold) begin
        start = 1'b1; op_lo = lo ^ 8'h55; mode = 3'd0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; is_write = 1'b0;
    op_lo = 8'h00; op_hi = 8'h00; index = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h00FF] = 8'h80; mem[16'h0000] = 8'h20;
    mem[16'h30FF] = 8'h40; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h60;
    mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    mem[16'h0040] = 8'hF8; mem[16'h0041] = 8'h07;
    tick(); tick();

    chk("rst_busy", 32'(busy_w[0]), 32'h0);
    chk("rst_ea", 32'(ea_w[0]), 32'h0);
    chk("rst_valid", 32'(ea_valid_w[0]), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd_w[0]), 32'h0);
    chk("rst_pc", 32'(pc_w[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // ZPI wraps inside page zero
    run(3'd1, 1'b0, 8'hF0, 8'h99, 8'h20, 0);
    chk("zpi_ea", 32'(ea_r[0]), 32'h0010);
    chk("zpi_lat", 32'(lat[0]), 32'd1);
    chk("zpi_pc", 32'(pc_r[0]), 32'h0);
    chk("zpi_nrd", 32'(nrd[0]), 32'd0);
    chk("zpi_busy_after", 32'(busy_w[0]), 32'h0);

    // ABSI read with page cross
    run(3'd3, 1'b0, 8'hFF, 8'h12, 8'h01, 0);
    chk("absi_x_ea", 32'(ea_r[0]), 32'h1300);
    chk("absi_x_pc", 32'(pc_r[0]), 32'h1);
    chk("absi_x_lat", 32'(lat[0]), 32'd2);
    chk("absi_x_lat_u1", 32'(lat[1]), 32'd2);

    // ZP ignores op_hi and clears page_cross
    run(3'd0, 1'b0, 8'h5A, 8'h99, 8'h33, 0);
    chk("zp_ea", 32'(ea_r[0]), 32'h005A);
    chk("zp_pc", 32'(pc_r[0]), 32'h0);
    chk("zp_lat", 32'(lat[0]), 32'd1);

    // Mode 7 behaves as ABS
    run(3'd7, 1'b0, 8'hCD, 8'hAB, 8'h10, 0);
    chk("m7_ea", 32'(ea_r[0]), 32'hABCD);
    chk("m7_lat", 32'(lat[0]), 32'd1);

    // ABSI read, no cross
    run(3'd3, 1'b0, 8'h10, 8'h12, 8'h01, 0);
    chk("absi_ea", 32'(ea_r[0]), 32'h1211);
    chk("absi_pc", 32'(pc_r[0]), 32'h0);
    chk("absi_lat", 32'(lat[0]), 32'd1);

    // ABSI store: fix cycle only where STORE_FIX is set
    run(3'd3, 1'b1, 8'h10, 8'h12, 8'h01, 0);
    chk("absi_st_lat_fix", 32'(lat[0]), 32'd2);
    chk("absi_st_lat_nofix", 32'(lat[1]), 32'd1);
    chk("absi_st_ea", 32'(ea_r[0]), 32'h1211);
    chk("absi_st_pc", 32'(pc_r[0]), 32'h0);

    // INDY with zero-page pointer wrap
    run(3'd5, 1'b0, 8'hFF, 8'h77, 8'h10, 0);
    chk("indy_nrd", 32'(nrd[0]), 32'd2);
    chk("indy_rd0", 32'(rd_a[0][0]), 32'h00FF);
    chk("indy_rd1", 32'(rd_a[0][1]), 32'h0000);
    chk("indy_ea", 32'(ea_r[0]), 32'h2090);
    chk("indy_pc", 32'(pc_r[0]), 32'h0);
    chk("indy_lat", 32'(lat[0]), 32'd4);

    // INDY page cross: 07F8+10
    run(3'd5, 1'b0, 8'h40, 8'h00, 8'h10, 0);
    chk("indy_x_ea", 32'(ea_r[0]), 32'h0808);
    chk("indy_x_pc", 32'(pc_r[0]), 32'h1);
    chk("indy_x_lat", 32'(lat[0]), 32'd5);

    // INDY store without cross
    run(3'd5, 1'b1, 8'hFF, 8'h00, 8'h10, 0);
    chk("indy_st_lat_fix", 32'(lat[0]), 32'd5);
    chk("indy_st_lat_nofix", 32'(lat[1]), 32'd4);

    // IND high-pointer address: in-page wrap vs full increment
    run(3'd6, 1'b0, 8'hFF, 8'h30, 8'h00, 0);
    chk("ind_rd0", 32'(rd_a[0][0]), 32'h30FF);
    chk("ind_bug_rd1", 32'(rd_a[0][1]), 32'h3000);
    chk("ind_bug_ea", 32'(ea_r[0]), 32'h5040);
    chk("ind_lat", 32'(lat[0]), 32'd4);
    chk("ind_nobug_rd1", 32'(rd_a[1][1]), 32'h3100);
    chk("ind_nobug_ea", 32'(ea_r[1]), 32'h6040);

    // INDX with start held during busy: must be ignored
    run(3'd4, 1'b0, 8'hFE, 8'h00, 8'h03, 2);
    chk("indx_rd0", 32'(rd_a[0][0]), 32'h0001);
    chk("indx_rd1", 32'(rd_a[0][1]), 32'h0002);
    chk("indx_ea", 32'(ea_r[0]), 32'h1234);
    chk("indx_lat", 32'(lat[0]), 32'd4);
    chk("indx_nvalid", 32'(nvalid[0]), 32'd1);
    chk("indx_nrd", 32'(nrd[0]), 32'd2);

    // Reset during RD_HI
    start = 1'b1; mode = 3'd4; op_lo = 8'hFE; index = 8'h03; is_write = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", 32'(busy_w[0]), 32'h1);
    chk("mid_mem_rd", 32'(mem_rd_w[0]), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rrst_busy", 32'(busy_w[0]), 32'h0);
    chk("rrst_mem_rd", 32'(mem_rd_w[0]), 32'h0);
    chk("rrst_mem_addr", 32'(mem_addr_w[0]), 32'h0);
    chk("rrst_ea", 32'(ea_w[0]), 32'h0);
    rst_n = 1'b1;
    run(3'd0, 1'b0, 8'h77, 8'h00, 8'h00, 0);
    chk("post_rst_ea", 32'(ea_r[0]), 32'h0077);
    chk("post_rst_lat", 32'(lat[0]), 32'd1);
    chk("post_rst_nvalid", 32'(nvalid[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
